// File: rtl/fpu_pkg.sv
// fpu_pkg
//    Field layout constants for IEEE-754 single precision plus the result
//    flag bit positions. The add/sub pipeline, this collector and writeback
//    all use it.
//    fp_classify() returns {nan,inf,zero} for a 32-bit value. Its callers
//    only use it when FP_RESULT_FLAGS_EN is defined.
package fpu_pkg;
   localparam int         FP_W         = 32;
   localparam int         EXP_MSB      = 30;
   localparam int         EXP_LSB      = 23;
   localparam int         MAN_MSB      = 22;
   localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

   localparam int FLAG_ZERO = 0;
   localparam int FLAG_INF  = 1;
   localparam int FLAG_NAN  = 2;
   localparam int FLAG_W    = 3;

   typedef logic [FLAG_W-1:0] fp_flags_t;

   function automatic fp_flags_t fp_classify(input logic [FP_W-1:0] v);
      fp_flags_t f;
      logic      exp_ones;
      logic      exp_zero;
      logic      man_zero;
      exp_ones     = (v[EXP_MSB:EXP_LSB] == EXP_ALL_ONES);
      exp_zero     = (v[EXP_MSB:EXP_LSB] == '0);
      man_zero     = (v[MAN_MSB:0] == '0);
      f            = '0;
      f[FLAG_ZERO] = exp_zero && man_zero;
      f[FLAG_INF]  = exp_ones && man_zero;
      f[FLAG_NAN]  = exp_ones && !man_zero;
      return f;
   endfunction
endpackage

// File: rtl/fp_result_collector_if.sv
// fp_result_collector_if
//    Groups the issue handshake, the pipeline C bus and the result handshake
//    of the FP result collector.
//    Signals:
//       issue_valid / issue_tag / issue_ready  upstream issue handshake
//       fp_c                                   C output of the add/sub pipeline
//       res_valid / res_ready                  result handshake toward writeback
//       res_data / res_tag                     head result and its tag
//       res_flags                              {nan,inf,zero}; exists only when
//                                              FP_RESULT_FLAGS_EN is defined
//    Modports:
//       master  upstream, pipeline and writeback side
//       slave   the collector
interface fp_result_collector_if
   import fpu_pkg::*;
#(
   parameter int TAG_W = 4
) ();
   logic             issue_valid;
   logic [TAG_W-1:0] issue_tag;
   logic             issue_ready;
   logic [FP_W-1:0]  fp_c;
   logic             res_valid;
   logic             res_ready;
   logic [FP_W-1:0]  res_data;
   logic [TAG_W-1:0] res_tag;
`ifdef FP_RESULT_FLAGS_EN
   logic [FLAG_W-1:0] res_flags;

   modport master (
      output issue_valid, issue_tag, fp_c, res_ready,
      input  issue_ready, res_valid, res_data, res_tag, res_flags
   );
   modport slave (
      input  issue_valid, issue_tag, fp_c, res_ready,
      output issue_ready, res_valid, res_data, res_tag, res_flags
   );
`else
   modport master (
      output issue_valid, issue_tag, fp_c, res_ready,
      input  issue_ready, res_valid, res_data, res_tag
   );
   modport slave (
      input  issue_valid, issue_tag, fp_c, res_ready,
      output issue_ready, res_valid, res_data, res_tag
   );
`endif
endinterface

// File: rtl/fp_result_fifo.sv
// fp_result_fifo
//    A FIFO of WIDTH-bit entries, DEPTH deep (DEPTH must be a power of two
//    and at least 2). The storage array has no reset. The head entry is held
//    in a register, which is loaded from storage through the read pointer.
//    Each pointer has one extra MSB, so the FIFO can tell full from empty.
//    Ports:
//       clk, rst              clock and asynchronous active-high reset
//       push, push_data       write one entry (the caller guarantees not full)
//       out_valid, out_ready  head handshake; a pop happens on valid && ready
//       out_data              registered head entry
module fp_result_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);
   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             empty;
   logic             full;
   logic             pop;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop       = !empty && out_ready;
   assign out_valid = !empty;
   assign out_data  = head_q;

   // The head register changes only when the head entry changes: on a pop,
   // or on a push into an empty FIFO. If the next head is the entry being
   // written on this same edge, it is taken from push_data, because storage
   // does not hold that entry yet.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      head_d   = head_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (pop || (empty && push)) begin
         if (push && (rd_ptr_d == wr_ptr_q)) begin
            head_d = push_data;
         end else begin
            head_d = mem[rd_ptr_d[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         head_q   <= head_d;
      end
   end

   // Credits should make a push while full impossible.
   push_when_full_a: assert property (@(posedge clk) disable iff (rst) !(push && full));
endmodule

// File: rtl/fp_result_collector.sv
// fp_result_collector
//    Sits downstream of the 5-stage FP add/sub pipeline. A valid/tag delay
//    line, LATENCY slots long, tracks which pipeline slots hold real
//    operations. When such an operation's C emerges, fp_c is captured into a
//    small FIFO. The FIFO drains to writeback through a valid/ready handshake.
//    Upstream is throttled with credits: issue_ready is low whenever
//    (FIFO occupancy + in-flight ops) has reached DEPTH. A result therefore
//    always finds a free FIFO slot.
//    Optional feature: define FP_RESULT_FLAGS_EN to classify each captured
//    result as {nan,inf,zero} and to add the res_flags port.
//    Ports:
//       clk, rst   clock and asynchronous active-high reset
//       bus        fp_result_collector_if.slave (issue, fp_c and result
//                  handshakes)
module fp_result_collector
   import fpu_pkg::*;
#(
   parameter int LATENCY = 5,
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   fp_result_collector_if.slave bus
);
   localparam int               CNT_W   = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
`ifdef FP_RESULT_FLAGS_EN
   localparam int ENTRY_W = FP_W + TAG_W + FLAG_W;
`else
   localparam int ENTRY_W = FP_W + TAG_W;
`endif

   logic               accept;
   logic               pop;
   logic [LATENCY-1:0] vbit_q, vbit_d;
   logic [TAG_W-1:0]   tag_q [LATENCY];
   logic [TAG_W-1:0]   tag_d [LATENCY];
   logic [CNT_W-1:0]   reserved_q, reserved_d;
   logic [ENTRY_W-1:0] push_data;
   logic [ENTRY_W-1:0] head_data;
   logic               head_valid;

   // issue_ready depends only on a register. A slot freed by a pop therefore
   // becomes visible one cycle later, and there is no path from res_ready to
   // issue_ready.
   assign bus.issue_ready = (reserved_q < CNT_MAX);
   assign accept          = bus.issue_valid && bus.issue_ready;
   assign pop             = head_valid && bus.res_ready;

   // Slot 0 is loaded on the accept edge. Slot LATENCY-1 is therefore set
   // during the cycle in which the pipeline presents that operation's C.
   always_comb begin
      vbit_d   = {vbit_q[LATENCY-2:0], accept};
      tag_d[0] = bus.issue_tag;
      for (int i = 1; i < LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end
   end

   // reserved counts every result that already owns a FIFO slot, whether it
   // is still in the pipeline or already stored.
   always_comb begin
      reserved_d = reserved_q;
      if (accept && !pop) begin
         reserved_d = reserved_q + CNT_ONE;
      end else if (pop && !accept) begin
         reserved_d = reserved_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vbit_q     <= '0;
         reserved_q <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         vbit_q     <= vbit_d;
         reserved_q <= reserved_d;
         for (int i = 0; i < LATENCY; i++) begin
            tag_q[i] <= tag_d[i];
         end
      end
   end

`ifdef FP_RESULT_FLAGS_EN
   assign push_data     = {fp_classify(bus.fp_c), tag_q[LATENCY-1], bus.fp_c};
   assign bus.res_flags = head_data[FP_W+TAG_W +: FLAG_W];
`else
   assign push_data = {tag_q[LATENCY-1], bus.fp_c};
`endif
   assign bus.res_data  = head_data[FP_W-1:0];
   assign bus.res_tag   = head_data[FP_W +: TAG_W];
   assign bus.res_valid = head_valid;

   fp_result_fifo #(
      .WIDTH(ENTRY_W),
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (vbit_q[LATENCY-1]),
      .push_data (push_data),
      .out_ready (bus.res_ready),
      .out_valid (head_valid),
      .out_data  (head_data)
   );
endmodule

// File: tb/tb_fp_result_collector.sv
// tb_fp_result_collector
//    Testbench for fp_result_collector. The bench plays the add/sub pipeline
//    itself. An operation accepted on edge k has its C presented on fp_c just
//    before edge k+LAT. In every other cycle, fp_c carries random garbage.
//    The reference model keeps three things: a queue of in-flight operations
//    with their capture edges, a queue of expected FIFO contents, and a count
//    of outstanding credits.
module tb_fp_result_collector;
   localparam int LAT   = 5;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   fp_result_collector_if #(.TAG_W(TAG_W)) bus ();

   fp_result_collector #(
      .LATENCY(LAT),
      .DEPTH  (DEPTH),
      .TAG_W  (TAG_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cap_edge;
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      bit               live;
   } op_t;

   typedef struct {
      logic [31:0]      data;
      logic [TAG_W-1:0] tag;
      logic [2:0]       flags;
   } res_t;

   op_t  inflight[$];
   res_t exp_q[$];
   int   outstanding = 0;
   int   edge_n      = 0;

   function automatic logic [2:0] ref_flags(input logic [31:0] v);
      int e;
      int m;
      e = int'(v[30:23]);
      m = int'(v[22:0]);
      return {(e == 255) && (m != 0), (e == 255) && (m == 0), (e == 0) && (m == 0)};
   endfunction

   function automatic logic [31:0] rand_value();
      logic [31:0] v;
      v = $urandom;
      case ($urandom_range(0, 5))
         0: v = 32'h0000_0000;
         1: v[30:23] = 8'hFF;
         2: v = 32'hFF80_0000;
         default: ;
      endcase
      return v;
   endfunction

   // Call this at a negedge. It drives one cycle of inputs, advances the model
   // across the following posedge, and returns at the next negedge.
   task automatic drive_cycle(input bit iv, input logic [TAG_W-1:0] tag,
                              input logic [31:0] data, input bit rr);
      bit          acc;
      bit          pp;
      bit          cap;
      logic [31:0] c;
      op_t         o;
      op_t         n;
      res_t        r;
      c   = $urandom;
      cap = 1'b0;
      if (inflight.size() > 0 && inflight[0].cap_edge == edge_n + 1) begin
         c   = inflight[0].data;
         cap = 1'b1;
      end
      bus.issue_valid = iv;
      bus.issue_tag   = tag;
      bus.fp_c        = c;
      bus.res_ready   = rr;
      acc = iv && (outstanding < DEPTH);
      pp  = rr && (exp_q.size() > 0);
      @(posedge clk);
      edge_n++;
      if (pp) begin
         $display("[%0t] pop tag=%h data=%h", $time, exp_q[0].tag, exp_q[0].data);
         void'(exp_q.pop_front());
         outstanding--;
      end
      if (cap) begin
         o = inflight.pop_front();
         if (o.live) begin
            r.data  = o.data;
            r.tag   = o.tag;
            r.flags = ref_flags(o.data);
            exp_q.push_back(r);
         end
      end
      if (acc) begin
         n.cap_edge = edge_n + LAT;
         n.data     = data;
         n.tag      = tag;
         n.live     = 1'b1;
         inflight.push_back(n);
         outstanding++;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.issue_valid = 1'b0;
      bus.issue_tag   = '0;
      bus.fp_c        = '0;
      bus.res_ready   = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (bus.res_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid);
      end
      n_cmp++;
      if (bus.issue_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset_issue_ready: got %b want 1", bus.issue_ready);
      end
      n_cmp++;
      if (bus.res_data !== 32'h0) begin
         n_bad++; $display("FAIL reset_res_data: got %h want 0", bus.res_data);
      end
      n_cmp++;
      if (bus.res_tag !== '0) begin
         n_bad++; $display("FAIL reset_res_tag: got %h want 0", bus.res_tag);
      end
`ifdef FP_RESULT_FLAGS_EN
      n_cmp++;
      if (bus.res_flags !== 3'b000) begin
         n_bad++; $display("FAIL reset_res_flags: got %b want 000", bus.res_flags);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_single_op();
      drive_cycle(1'b1, 4'd3, 32'h4040_0000, 1'b0);
      for (int i = 1; i <= LAT; i++) begin
         drive_cycle(1'b0, '0, '0, 1'b0);
         n_cmp++;
         if (bus.res_valid !== (i == LAT)) begin
            n_bad++; $display("FAIL single_latency: edge+%0d res_valid got %b want %b",
                              i, bus.res_valid, (i == LAT));
         end
      end
      n_cmp++;
      if (bus.res_data !== 32'h4040_0000 || bus.res_tag !== 4'd3) begin
         n_bad++; $display("FAIL single_result: got %h/%h want 40400000/3", bus.res_data, bus.res_tag);
      end
      drive_cycle(1'b0, '0, '0, 1'b1);
      n_cmp++;
      if (bus.res_valid !== 1'b0) begin
         n_bad++; $display("FAIL single_pop: res_valid got %b want 0", bus.res_valid);
      end
   endtask

   task automatic test_credit_stall();
      int acc_cnt;
      acc_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (bus.issue_ready !== (outstanding < DEPTH)) begin
            n_bad++; $display("FAIL stall_issue_ready: cycle %0d got %b want %b",
                              i, bus.issue_ready, (outstanding < DEPTH));
         end
         if (bus.issue_ready === 1'b1) acc_cnt++;
         drive_cycle(1'b1, TAG_W'(i), $urandom, 1'b0);
      end
      n_cmp++;
      if (acc_cnt != DEPTH) begin
         n_bad++; $display("FAIL stall_accept_count: got %0d want %0d", acc_cnt, DEPTH);
      end
      repeat (LAT + 1) drive_cycle(1'b0, '0, '0, 1'b0);
      n_cmp++;
      if (bus.issue_ready !== 1'b0 || bus.res_valid !== 1'b1) begin
         n_bad++; $display("FAIL stall_full: issue_ready/res_valid got %b/%b want 0/1",
                           bus.issue_ready, bus.res_valid);
      end
      n_cmp++;
      if (bus.res_tag !== 4'd0) begin
         n_bad++; $display("FAIL stall_head_tag: got %h want 0", bus.res_tag);
      end
      drive_cycle(1'b0, '0, '0, 1'b1);
      n_cmp++;
      if (bus.issue_ready !== 1'b1) begin
         n_bad++; $display("FAIL stall_credit_return: issue_ready got %b want 1", bus.issue_ready);
      end
      for (int i = 0; i < DEPTH - 1; i++) begin
         n_cmp++;
         if (bus.res_valid !== 1'b1 || exp_q.size() == 0 ||
             bus.res_data !== exp_q[0].data || bus.res_tag !== exp_q[0].tag) begin
            n_bad++; $display("FAIL stall_drain: got v=%b %h/%h want %0d queued",
                              bus.res_valid, bus.res_data, bus.res_tag, exp_q.size());
         end
         drive_cycle(1'b0, '0, '0, 1'b1);
      end
   endtask

   task automatic test_gaps();
      int cnt;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         drive_cycle(i != 1, TAG_W'(i + 8), $urandom, 1'b0);
      end
      repeat (LAT + 1) drive_cycle(1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         if (bus.res_valid === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0 || bus.res_data !== exp_q[0].data || bus.res_tag !== exp_q[0].tag) begin
               n_bad++; $display("FAIL gaps_entry: got %h/%h want %0d queued",
                                 bus.res_data, bus.res_tag, exp_q.size());
            end
            cnt++;
         end
         drive_cycle(1'b0, '0, '0, 1'b1);
      end
      n_cmp++;
      if (cnt != 3) begin
         n_bad++; $display("FAIL gaps_count: got %0d entries want 3", cnt);
      end
   endtask

   task automatic test_push_pop();
      drive_cycle(1'b1, 4'h5, $urandom, 1'b0);
      drive_cycle(1'b1, 4'h6, $urandom, 1'b0);
      repeat (LAT) drive_cycle(1'b0, '0, '0, 1'b0);
      for (int r = 0; r < 6; r++) begin
         drive_cycle(1'b1, TAG_W'(r + 7), $urandom, 1'b0);
         for (int j = 1; j <= LAT; j++) begin
            if (j == LAT) begin
               n_cmp++;
               if (bus.res_valid !== 1'b1 || exp_q.size() == 0 ||
                   bus.res_data !== exp_q[0].data || bus.res_tag !== exp_q[0].tag) begin
                  n_bad++; $display("FAIL pushpop_head: round %0d got v=%b %h/%h", r,
                                    bus.res_valid, bus.res_data, bus.res_tag);
               end
            end
            drive_cycle(1'b0, '0, '0, j == LAT);
         end
         n_cmp++;
         if (bus.res_valid !== 1'b1) begin
            n_bad++; $display("FAIL pushpop_valid: round %0d got %b want 1", r, bus.res_valid);
         end
      end
      for (int i = 0; i < 2; i++) begin
         n_cmp++;
         if (bus.res_valid !== 1'b1 || exp_q.size() == 0 || bus.res_tag !== exp_q[0].tag) begin
            n_bad++; $display("FAIL pushpop_drain: got v=%b tag=%h", bus.res_valid, bus.res_tag);
         end
         drive_cycle(1'b0, '0, '0, 1'b1);
      end
      n_cmp++;
      if (bus.res_valid !== 1'b0) begin
         n_bad++; $display("FAIL pushpop_empty: res_valid got %b want 0", bus.res_valid);
      end
   endtask

`ifdef FP_RESULT_FLAGS_EN
   task automatic test_flags();
      logic [31:0] vals [3];
      logic [2:0]  want [3];
      vals = '{32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000};
      want = '{3'b001, 3'b010, 3'b100};
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, TAG_W'(i), vals[i], 1'b0);
      repeat (LAT) drive_cycle(1'b0, '0, '0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (bus.res_valid !== 1'b1 || bus.res_flags !== want[i]) begin
            n_bad++; $display("FAIL flags_%0d: got v=%b flags=%b want flags=%b",
                              i, bus.res_valid, bus.res_flags, want[i]);
         end
         drive_cycle(1'b0, '0, '0, 1'b1);
      end
   endtask
`endif

   task automatic test_reset_midflight();
      drive_cycle(1'b1, 4'hA, $urandom, 1'b0);
      repeat (LAT) drive_cycle(1'b0, '0, '0, 1'b0);
      n_cmp++;
      if (bus.res_valid !== 1'b1) begin
         n_bad++; $display("FAIL flush_pre_valid: got %b want 1", bus.res_valid);
      end
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, TAG_W'(i + 1), $urandom, 1'b0);
      n_cmp++;
      if (bus.issue_ready !== 1'b0) begin
         n_bad++; $display("FAIL flush_pre_ready: got %b want 0", bus.issue_ready);
      end
      #2;
      rst = 1'b1;
      exp_q.delete();
      outstanding = 0;
      for (int i = 0; i < inflight.size(); i++) inflight[i].live = 1'b0;
      #2;
      n_cmp++;
      if (bus.res_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
         n_bad++; $display("FAIL flush_immediate: res_valid/issue_ready got %b/%b want 0/1",
                           bus.res_valid, bus.issue_ready);
      end
      rst = 1'b0;
      for (int i = 0; i < LAT + 2; i++) begin
         drive_cycle(1'b0, '0, '0, 1'b1);
         n_cmp++;
         if (bus.res_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_ghost: cycle %0d res_valid got %b want 0", i, bus.res_valid);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         n_cmp++;
         if (bus.issue_ready !== (outstanding < DEPTH)) begin
            n_bad++; $display("FAIL rand_issue_ready: cycle %0d got %b want %b",
                              i, bus.issue_ready, (outstanding < DEPTH));
         end
         n_cmp++;
         if (bus.res_valid !== (exp_q.size() > 0)) begin
            n_bad++; $display("FAIL rand_res_valid: cycle %0d got %b want %b",
                              i, bus.res_valid, (exp_q.size() > 0));
         end
         if (bus.res_valid === 1'b1 && exp_q.size() > 0) begin
            n_cmp++;
            if (bus.res_data !== exp_q[0].data || bus.res_tag !== exp_q[0].tag) begin
               n_bad++; $display("FAIL rand_head: cycle %0d got %h/%h want %h/%h", i,
                                 bus.res_data, bus.res_tag, exp_q[0].data, exp_q[0].tag);
            end
`ifdef FP_RESULT_FLAGS_EN
            n_cmp++;
            if (bus.res_flags !== exp_q[0].flags) begin
               n_bad++; $display("FAIL rand_flags: cycle %0d got %b want %b",
                                 i, bus.res_flags, exp_q[0].flags);
            end
`endif
         end
         drive_cycle($urandom_range(0, 99) < 70, TAG_W'($urandom_range(0, 15)),
                     rand_value(), $urandom_range(0, 99) < 55);
      end
      repeat (LAT + DEPTH + 2) drive_cycle(1'b0, '0, '0, 1'b1);
      n_cmp++;
      if (bus.res_valid !== 1'b0 || bus.issue_ready !== 1'b1) begin
         n_bad++; $display("FAIL rand_drained: res_valid/issue_ready got %b/%b want 0/1",
                           bus.res_valid, bus.issue_ready);
      end
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_credit_stall();
      test_gaps();
      test_push_pop();
`ifdef FP_RESULT_FLAGS_EN
      test_flags();
`endif
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
